rr_mux4_arbiter: RTL

- Round-robin arbiter and sequencer wrapped around a 4:1 multiplexer.
- Four requesters (a, b, c, d lanes, indices 0..3) share one output channel. The block owns the mux select and grants one requester at a time.
- Output side uses a valid/ready handshake.
- A per-grant beat limit bounds how long one requester can hold the channel.

---
 rtl/rr_mux4_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rr_mux4_arbiter.sv
// rtl/rr_mux4_arbiter.sv - round-robin arbiter and sequencer around a 4:1 data mux
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req[3:0]          per-lane request, bit i = lane i
//   a, b, c, d        lane 0..3 data (DW bits)
//   gnt[3:0]          registered one-hot grant, zero when idle
//   s[1:0]            registered mux select, index of the gnt bit
//   y                 muxed data, zero when out_valid=0
//   out_valid         y holds a beat (granted lane still requesting)
//   out_ready         downstream accepts the beat
//   busy              arbiter is in GRANT
//
// Optional macro: ARB_FIXED_PRIO_EN - lane 0 highest priority, ptr frozen.
module rr_mux4_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [3:0]    gnt,
  output logic [1:0]    s,
  output logic [DW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam int            BW        = $clog2(MAX_HOLD + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [1:0]    r_s, w_s_nxt;
  logic [3:0]    r_gnt, w_gnt_nxt;
  logic [BW-1:0] r_beat_cnt, w_beat_nxt;

  logic          w_out_valid;
  logic          w_xfer;
  logic [1:0]    w_start;
  logic [2:0]    w_pick;

  // Returns {found, index}. Scanning offsets from highest to lowest lets the
  // smallest offset from start overwrite any later match.
  function automatic logic [2:0] pick(input logic [1:0] start, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // IDLE scans from the saved pointer; a rearbitration in GRANT scans from
  // the lane after the current one, which becomes the new pointer.
`ifdef ARB_FIXED_PRIO_EN
  assign w_start = 2'b00;
`else
  assign w_start = (r_state == IDLE) ? r_ptr : (r_s + 2'd1);
`endif
  assign w_pick = pick(w_start, req);

  assign w_out_valid = (r_state == GRANT) && req[r_s];
  assign w_xfer      = w_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= 2'b00;
      r_s        <= 2'b00;
      r_gnt      <= 4'b0000;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_s        <= w_s_nxt;
      r_gnt      <= w_gnt_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_s_nxt     = r_s;
    w_gnt_nxt   = r_gnt;
    w_beat_nxt  = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt = GRANT;
          w_s_nxt     = w_pick[1:0];
          w_gnt_nxt   = 4'b0001 << w_pick[1:0];
          w_beat_nxt  = '0;
        end
      end
      GRANT: begin
        if (w_xfer && (r_beat_cnt < LAST_BEAT)) begin
          w_beat_nxt = r_beat_cnt + BW'(1);
        end else if (w_xfer || !req[r_s]) begin
          // Hold limit reached or requester released: pick the next lane
          // on this same edge; a sole requester wraps back to itself.
`ifndef ARB_FIXED_PRIO_EN
          w_ptr_nxt = r_s + 2'd1;
`endif
          if (w_pick[2]) begin
            w_s_nxt    = w_pick[1:0];
            w_gnt_nxt  = 4'b0001 << w_pick[1:0];
            w_beat_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = 4'b0000;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    y = '0;
    if (w_out_valid) begin
      case (r_s)
        2'd0:    y = a;
        2'd1:    y = b;
        2'd2:    y = c;
        default: y = d;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign s         = r_s;
  assign out_valid = w_out_valid;
  assign busy      = (r_state == GRANT);

endmodule
